// File: rtl/game_update_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared constants, state encoding and box-overlap helper for
//               the once-per-frame game-state controller.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Playfield interior, inclusive, in pixels
    localparam logic [11:0] c_bound_min  = 12'd11;
    localparam logic [11:0] c_x_max      = 12'd1428;
    localparam logic [11:0] c_y_max      = 12'd888;

    // Reset positions
    localparam logic [10:0] c_pos_x_rst  = 11'd720;
    localparam logic [9:0]  c_pos_y_rst  = 10'd450;
    localparam logic [10:0] c_food_x_rst = 11'd300;
    localparam logic [9:0]  c_food_y_rst = 10'd300;

    // Food geometry and candidate window for relocation
    localparam logic [11:0] c_food_half  = 12'd8;
    localparam logic [11:0] c_cand_off   = 12'd19;
    localparam logic [11:0] c_cand_x_max = 12'd1420;
    localparam logic [11:0] c_cand_y_max = 12'd880;

    // LFSR: x^16 + x^14 + x^13 + x^11, taps at bit indices 15,13,12,10
    localparam logic [15:0] c_lfsr_seed  = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps  = 16'hB400;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MOVE     = 3'd1,
        COLLIDE  = 3'd2,
        RELOCATE = 3'd3,
        COMMIT   = 3'd4
    } state_t;

    // Character box (half-size 'half') against a food box (half-size 8).
    // Only additions are used so nothing can wrap below zero.
    function automatic logic box_hit(input logic [11:0] cx,
                                     input logic [11:0] cy,
                                     input logic [11:0] ox,
                                     input logic [11:0] oy,
                                     input logic [11:0] half);
        logic [11:0] reach;
        reach = half + c_food_half;
        return (cx + reach > ox) && (ox + reach > cx) &&
               (cy + reach > oy) && (oy + reach > cy);
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_update_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : game_update_ctrl_if
// Description : Frame-timing/button inputs and game-state outputs of the
//               game update controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_update_ctrl_if;

    logic        vblank_start;
    logic        btn_up;
    logic        btn_down;
    logic        btn_left;
    logic        btn_right;
    logic [10:0] characterPos_x;
    logic [9:0]  characterPos_y;
    logic [7:0]  characterSize;
    logic [10:0] foodPos_x;
    logic [9:0]  foodPos_y;
    logic [7:0]  score;
    logic        busy;

    // Video timing / input side
    modport master (
        output vblank_start, btn_up, btn_down, btn_left, btn_right,
        input  characterPos_x, characterPos_y, characterSize,
               foodPos_x, foodPos_y, score, busy
    );

    // Controller side
    modport slave (
        input  vblank_start, btn_up, btn_down, btn_left, btn_right,
        output characterPos_x, characterPos_y, characterSize,
               foodPos_x, foodPos_y, score, busy
    );

endinterface
`default_nettype wire

// File: rtl/game_update_ctrl_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Fibonacci LFSR used as the food
//               placement random source.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import game_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    output logic [15:0]      out
);

    logic [15:0] r_state;
    logic        w_fb;

    // Feedback is the XOR of the tapped bits
    assign w_fb = ^(r_state & c_lfsr_taps);

    // Shift every clock, regardless of controller state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_lfsr_seed;
        end else begin
            r_state <= {r_state[14:0], w_fb};
        end
    end

    assign out = r_state;

endmodule
`default_nettype wire

// File: rtl/game_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_update_ctrl
// Description : Once-per-frame game-state controller. Moves and clamps the
//               character, detects food collisions, grows the character,
//               relocates the food and commits everything atomically.
// Revision    : 1.0 - initial release
// ============================================================================
module game_update_ctrl
    import game_pkg::*;
#(
    parameter int STEP      = 4,
    parameter int SIZE_INIT = 16,
    parameter int SIZE_INC  = 4,
    parameter int SIZE_MAX  = 128,
    parameter int MAX_TRIES = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    game_update_ctrl_if.slave bus
);

    localparam int c_try_w = $clog2(MAX_TRIES + 1);

    state_t               r_state;
    logic [3:0]           r_btn;        // {up, down, left, right}
    logic [c_try_w-1:0]   r_try;

    // Shadow copy worked on during the sequence
    logic [10:0]          r_sh_x;
    logic [9:0]           r_sh_y;
    logic [7:0]           r_sh_size;
    logic [10:0]          r_sh_fx;
    logic [9:0]           r_sh_fy;
    logic [7:0]           r_sh_score;

    // Committed, externally visible copy
    logic [10:0]          r_pos_x;
    logic [9:0]           r_pos_y;
    logic [7:0]           r_size;
    logic [10:0]          r_food_x;
    logic [9:0]           r_food_y;
    logic [7:0]           r_score;
    logic                 r_busy;

    logic [15:0]          w_lfsr;
    logic [11:0]          w_half;
    logic [11:0]          w_cx;
    logic [11:0]          w_cy;
    logic [11:0]          w_lo;
    logic [11:0]          w_x_hi;
    logic [11:0]          w_y_hi;
    logic [11:0]          w_nx;
    logic [11:0]          w_ny;
    logic [11:0]          w_mx;
    logic [11:0]          w_my;
    logic                 w_hit;
    logic [11:0]          w_cand_x;
    logic [11:0]          w_cand_y;
    logic                 w_cand_ok;
    logic [8:0]           w_size_sum;
    logic [7:0]           w_size_next;

    lfsr16 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (w_lfsr)
    );

    // Move/clamp, collision and candidate evaluation on the shadow state
    always_comb begin
        w_half = {5'd0, r_sh_size[7:1]};
        w_cx   = {1'b0, r_sh_x};
        w_cy   = {2'b0, r_sh_y};
        w_lo   = c_bound_min + w_half;
        w_x_hi = c_x_max - w_half;
        w_y_hi = c_y_max - w_half;

        // Opposing buttons cancel; the centre never drops below 11 so
        // subtracting STEP cannot wrap.
        w_nx = w_cx;
        if (r_btn[1] && !r_btn[0]) begin
            w_nx = w_cx - 12'(STEP);
        end else if (r_btn[0] && !r_btn[1]) begin
            w_nx = w_cx + 12'(STEP);
        end
        w_ny = w_cy;
        if (r_btn[3] && !r_btn[2]) begin
            w_ny = w_cy - 12'(STEP);
        end else if (r_btn[2] && !r_btn[3]) begin
            w_ny = w_cy + 12'(STEP);
        end

        // Clamping always runs, which also pulls back a box that grew
        // over a wall on the previous frame.
        w_mx = w_nx;
        if (w_nx < w_lo) begin
            w_mx = w_lo;
        end else if (w_nx > w_x_hi) begin
            w_mx = w_x_hi;
        end
        w_my = w_ny;
        if (w_ny < w_lo) begin
            w_my = w_lo;
        end else if (w_ny > w_y_hi) begin
            w_my = w_y_hi;
        end

        w_hit = box_hit(w_cx, w_cy, {1'b0, r_sh_fx}, {2'b0, r_sh_fy}, w_half);

        // In RELOCATE the shadow size is already the grown size
        w_cand_x  = {1'b0, w_lfsr[10:0]} + c_cand_off;
        w_cand_y  = {2'b0, w_lfsr[15:6]} + c_cand_off;
        w_cand_ok = (w_cand_x <= c_cand_x_max) && (w_cand_y <= c_cand_y_max) &&
                    !box_hit(w_cx, w_cy, w_cand_x, w_cand_y, w_half);

        w_size_sum  = {1'b0, r_sh_size} + 9'(SIZE_INC);
        w_size_next = (w_size_sum > 9'(SIZE_MAX)) ? 8'(SIZE_MAX) : 8'(w_size_sum);
    end

    // Update sequencer: works on the shadow copy, publishes it in COMMIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_btn      <= 4'd0;
            r_try      <= '0;
            r_sh_x     <= c_pos_x_rst;
            r_sh_y     <= c_pos_y_rst;
            r_sh_size  <= 8'(SIZE_INIT);
            r_sh_fx    <= c_food_x_rst;
            r_sh_fy    <= c_food_y_rst;
            r_sh_score <= 8'd0;
            r_pos_x    <= c_pos_x_rst;
            r_pos_y    <= c_pos_y_rst;
            r_size     <= 8'(SIZE_INIT);
            r_food_x   <= c_food_x_rst;
            r_food_y   <= c_food_y_rst;
            r_score    <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.vblank_start) begin
                        r_btn   <= {bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
                        r_busy  <= 1'b1;
                        r_state <= MOVE;
                    end
                end
                MOVE: begin
                    r_sh_x  <= 11'(w_mx);
                    r_sh_y  <= 10'(w_my);
                    r_state <= COLLIDE;
                end
                COLLIDE: begin
                    if (w_hit) begin
                        if (r_sh_score != 8'hFF) begin
                            r_sh_score <= r_sh_score + 8'd1;
                        end
                        r_sh_size <= w_size_next;
                        r_try     <= '0;
                        r_state   <= RELOCATE;
                    end else begin
                        r_state <= COMMIT;
                    end
                end
                RELOCATE: begin
                    if (w_cand_ok) begin
                        r_sh_fx <= 11'(w_cand_x);
                        r_sh_fy <= 10'(w_cand_y);
                        r_state <= COMMIT;
                    end else if (r_try == c_try_w'(MAX_TRIES - 1)) begin
                        r_sh_fx <= c_pos_x_rst;
                        r_sh_fy <= c_pos_y_rst;
                        r_state <= COMMIT;
                    end else begin
                        r_try <= r_try + 1'b1;
                    end
                end
                COMMIT: begin
                    r_pos_x  <= r_sh_x;
                    r_pos_y  <= r_sh_y;
                    r_size   <= r_sh_size;
                    r_food_x <= r_sh_fx;
                    r_food_y <= r_sh_fy;
                    r_score  <= r_sh_score;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.characterPos_x = r_pos_x;
    assign bus.characterPos_y = r_pos_y;
    assign bus.characterSize  = r_size;
    assign bus.foodPos_x      = r_food_x;
    assign bus.foodPos_y      = r_food_y;
    assign bus.score          = r_score;
    assign bus.busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_game_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_update_ctrl
// Description : Directed self-checking bench for game_update_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_update_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc;
    logic early;

    game_update_ctrl_if bus ();

    game_update_ctrl #(
        .STEP      (4),
        .SIZE_INIT (16),
        .SIZE_INC  (4),
        .SIZE_MAX  (128),
        .MAX_TRIES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [57:0] snap();
        return {bus.characterPos_x, bus.characterPos_y, bus.characterSize,
                bus.foodPos_x, bus.foodPos_y, bus.score};
    endfunction

    // One frame: pulse at a negedge, then count busy cycles at negedges.
    // 'early' flags any output change while busy is still high.
    task automatic do_frame(input logic u, input logic d, input logic l, input logic r,
                            output int n, output logic e);
        logic [57:0] s;
        s = snap();
        e = 1'b0;
        bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
        bus.vblank_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.vblank_start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            if (snap() !== s) e = 1'b1;
            @(negedge clk);
        end
        if (n >= 40) chk("frame_timeout_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // From reset: 37 up+left frames to (572,302), then left until the hit
    // at x=312 against the food at (300,300).
    task automatic approach(output int n, output logic e);
        n = 0; e = 1'b0;
        repeat (37) do_frame(1, 0, 1, 0, n, e);
        for (int k = 0; k < 80 && bus.score == 8'd0; k++) do_frame(0, 0, 1, 0, n, e);
        if (bus.score == 8'd0) chk("hit_timeout_score", 32'(bus.score), 32'd1);
    endtask

    initial begin
        int fx, fy;
        bus.vblank_start = 1'b0;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_x", 32'(bus.characterPos_x), 720);
        chk("rst_y", 32'(bus.characterPos_y), 450);
        chk("rst_size", 32'(bus.characterSize), 16);
        chk("rst_fx", 32'(bus.foodPos_x), 300);
        chk("rst_fy", 32'(bus.foodPos_y), 300);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Idle frames, no buttons
        repeat (2) do_frame(0, 0, 0, 0, cyc, early);
        chk("idle_busy_cycles", 32'(cyc), 3);
        chk("idle_x", 32'(bus.characterPos_x), 720);
        chk("idle_y", 32'(bus.characterPos_y), 450);
        chk("idle_size", 32'(bus.characterSize), 16);
        chk("idle_fx", 32'(bus.foodPos_x), 300);
        chk("idle_score", 32'(bus.score), 0);

        // Right for three frames: 3 busy cycles each, outputs only at T+4
        for (int i = 0; i < 3; i++) begin
            do_frame(0, 0, 0, 1, cyc, early);
            chk("right_busy_cycles", 32'(cyc), 3);
            chk("right_early_change", 32'(early), 0);
            chk("right_x_step", 32'(bus.characterPos_x), 32'(724 + 4 * i));
        end
        chk("right_x", 32'(bus.characterPos_x), 732);
        chk("right_y", 32'(bus.characterPos_y), 450);

        // Left+right cancel, up moves y by -4, then clamp at the top edge
        do_frame(1, 0, 1, 1, cyc, early);
        chk("lru_x1", 32'(bus.characterPos_x), 732);
        chk("lru_y1", 32'(bus.characterPos_y), 446);
        do_frame(1, 0, 1, 1, cyc, early);
        chk("lru_y2", 32'(bus.characterPos_y), 442);
        repeat (110) do_frame(1, 0, 1, 1, cyc, early);
        chk("top_clamp_y", 32'(bus.characterPos_y), 19);
        chk("top_clamp_x", 32'(bus.characterPos_x), 732);

        // Second vblank_start while busy is dropped, not queued
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b1;
        bus.vblank_start = 1'b1;
        @(posedge clk);
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.vblank_start = (k == 1);
            if (bus.busy === 1'b1) cyc++;
        end
        chk("ignored_pulse_busy", 32'(cyc), 3);
        chk("ignored_pulse_x", 32'(bus.characterPos_x), 736);
        bus.btn_right = 1'b0;

        // Eat the food with the real LFSR
        pulse_reset();
        approach(cyc, early);
        chk("hit_x", 32'(bus.characterPos_x), 312);
        chk("hit_y", 32'(bus.characterPos_y), 302);
        chk("hit_score", 32'(bus.score), 1);
        chk("hit_size", 32'(bus.characterSize), 20);
        chk("hit_busy_range", 32'(cyc >= 4 && cyc <= 19), 1);
        chk("hit_early_change", 32'(early), 0);
        fx = int'(bus.foodPos_x);
        fy = int'(bus.foodPos_y);
        chk("food_x_range", 32'(fx >= 19 && fx <= 1420), 1);
        chk("food_y_range", 32'(fy >= 19 && fy <= 880), 1);
        // New half-size 10 plus food half 8: boxes overlap iff |d| < 18 on both axes
        chk("food_no_overlap",
            32'(fx >= 312 + 18 || fx + 18 <= 312 || fy >= 302 + 18 || fy + 18 <= 302), 1);

        // Every candidate rejected: fallback after exactly 16 RELOCATE cycles
        pulse_reset();
        force dut.w_lfsr = 16'hFFFF;
        approach(cyc, early);
        chk("fallback_busy_cycles", 32'(cyc), 19);
        chk("fallback_fx", 32'(bus.foodPos_x), 720);
        chk("fallback_fy", 32'(bus.foodPos_y), 450);
        chk("fallback_score", 32'(bus.score), 1);
        chk("fallback_size", 32'(bus.characterSize), 20);

        // Reset in the middle of RELOCATE
        pulse_reset();
        repeat (37) do_frame(1, 0, 1, 0, cyc, early);
        repeat (64) do_frame(0, 0, 1, 0, cyc, early);
        chk("pre_abort_x", 32'(bus.characterPos_x), 316);
        chk("pre_abort_score", 32'(bus.score), 0);
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_left = 1'b1; bus.btn_right = 1'b0;
        bus.vblank_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.vblank_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 1);
        chk("abort_x_before", 32'(bus.characterPos_x), 316);
        rst = 1'b1;
        #1;
        chk("abort_x", 32'(bus.characterPos_x), 720);
        chk("abort_y", 32'(bus.characterPos_y), 450);
        chk("abort_size", 32'(bus.characterSize), 16);
        chk("abort_fx", 32'(bus.foodPos_x), 300);
        chk("abort_fy", 32'(bus.foodPos_y), 300);
        chk("abort_score", 32'(bus.score), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        release dut.w_lfsr;
        bus.btn_left = 1'b0;
        @(negedge clk);
        do_frame(0, 0, 0, 0, cyc, early);
        chk("post_abort_busy_cycles", 32'(cyc), 3);
        chk("post_abort_x", 32'(bus.characterPos_x), 720);
        chk("post_abort_score", 32'(bus.score), 0);
        chk("post_abort_size", 32'(bus.characterSize), 16);
        chk("post_abort_fx", 32'(bus.foodPos_x), 300);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
